// File: rtl/inst_decode.sv
// inst_decode: instruction decode stage with one registered output slot.
// Splits each 20-bit word into opcode and three register fields, tags it with
// the program counter it was fetched from, and stops accepting on HALT.
// Optional feature macro: HAZARD_DETECT_EN (adds a RAW hazard flag that
// compares the new source registers against the previous destination).
module inst_decode #(
  parameter int INST_W = 20,
  parameter int REG_W  = 6,
  parameter int PC_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [INST_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic              i_ex_ready,
  output logic              o_dec_valid,
  output logic [1:0]        o_dec_op,
  output logic [REG_W-1:0]  o_dec_rs1,
  output logic [REG_W-1:0]  o_dec_rs2,
  output logic [REG_W-1:0]  o_dec_rd,
  output logic [PC_W-1:0]   o_dec_pc,
  output logic              o_dec_hazard,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_inst_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_issue;
  logic               w_is_halt;
  logic [1:0]         w_op;
  logic [REG_W-1:0]   w_rs1;
  logic [REG_W-1:0]   w_rs2;
  logic [REG_W-1:0]   w_rd;

  logic [PC_W-1:0]    r_pc;
  logic               r_dec_valid;
  logic [1:0]         r_dec_op;
  logic [REG_W-1:0]   r_dec_rs1;
  logic [REG_W-1:0]   r_dec_rs2;
  logic [REG_W-1:0]   r_dec_rd;
  logic [PC_W-1:0]    r_dec_pc;
  logic [CNT_W-1:0]   r_inst_count;

  assign w_op      = i_in_data[INST_W-1 -: 2];
  assign w_rs1     = i_in_data[2*REG_W +: REG_W];
  assign w_rs2     = i_in_data[REG_W +: REG_W];
  assign w_rd      = i_in_data[0 +: REG_W];
  assign w_is_halt = (w_op == 2'b11);
  assign w_accept  = i_in_valid && o_in_ready;
  assign w_issue   = r_dec_valid && i_ex_ready;

  // State register: RUN until a HALT word is consumed, then idle until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_next_state;
  end

  // Next state and fetch back-pressure; ready only when the slot frees up.
  always_comb begin
    w_next_state = r_state;
    o_in_ready   = 1'b0;
    case (r_state)
      RUN: begin
        o_in_ready = !r_dec_valid || i_ex_ready;
        if (w_accept && w_is_halt) w_next_state = HALTED;
      end
      HALTED: begin
        o_in_ready   = 1'b0;
        w_next_state = HALTED;
      end
      default: w_next_state = RUN;
    endcase
  end

  // Output slot, program counter and issue counter; reload wins over drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc         <= '0;
      r_dec_valid  <= 1'b0;
      r_dec_op     <= '0;
      r_dec_rs1    <= '0;
      r_dec_rs2    <= '0;
      r_dec_rd     <= '0;
      r_dec_pc     <= '0;
      r_inst_count <= '0;
    end else begin
      if (w_accept) r_pc <= r_pc + 1'b1;
      if (w_issue) r_inst_count <= r_inst_count + 1'b1;
      if (w_accept && !w_is_halt) begin
        r_dec_valid <= 1'b1;
        r_dec_op    <= w_op;
        r_dec_rs1   <= w_rs1;
        r_dec_rs2   <= w_rs2;
        r_dec_rd    <= w_rd;
        r_dec_pc    <= r_pc;
      end else if (w_issue) begin
        r_dec_valid <= 1'b0;
      end
    end
  end

`ifdef HAZARD_DETECT_EN
  logic             r_dec_hazard;
  logic [REG_W-1:0] r_last_rd;
  logic             r_last_vld;

  // Hazard tracker: remembers the destination of the last non-HALT word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dec_hazard <= 1'b0;
      r_last_rd    <= '0;
      r_last_vld   <= 1'b0;
    end else if (w_accept && !w_is_halt) begin
      r_dec_hazard <= r_last_vld && ((w_rs1 == r_last_rd) || (w_rs2 == r_last_rd));
      r_last_rd    <= w_rd;
      r_last_vld   <= 1'b1;
    end
  end

  assign o_dec_hazard = r_dec_hazard;
`else
  assign o_dec_hazard = 1'b0;
`endif

  assign o_dec_valid  = r_dec_valid;
  assign o_dec_op     = r_dec_op;
  assign o_dec_rs1    = r_dec_rs1;
  assign o_dec_rs2    = r_dec_rs2;
  assign o_dec_rd     = r_dec_rd;
  assign o_dec_pc     = r_dec_pc;
  assign o_halted     = (r_state == HALTED);
  assign o_inst_count = r_inst_count;

endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: directed and randomized stimulus for inst_decode, checked
// against a transaction-level model (pending-instruction queue, counters).
module tb_inst_decode;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [19:0] inData;
  logic        inReady;
  logic        exReady;
  logic        decValid;
  logic [1:0]  decOp;
  logic [5:0]  decRs1;
  logic [5:0]  decRs2;
  logic [5:0]  decRd;
  logic [4:0]  decPc;
  logic        decHazard;
  logic        halted;
  logic [15:0] instCount;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    int op;
    int rs1;
    int rs2;
    int rd;
    int pc;
    int hz;
  } inst_t;

  // Reference model state: instructions waiting for execute, plus counters.
  inst_t pending[$];
  int    mPc;
  int    mCount;
  bit    mHalted;
  bit    haveLast;
  int    lastRd;

  inst_decode dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .i_in_data   (inData),
    .o_in_ready  (inReady),
    .i_ex_ready  (exReady),
    .o_dec_valid (decValid),
    .o_dec_op    (decOp),
    .o_dec_rs1   (decRs1),
    .o_dec_rs2   (decRs2),
    .o_dec_rd    (decRd),
    .o_dec_pc    (decPc),
    .o_dec_hazard(decHazard),
    .o_halted    (halted),
    .o_inst_count(instCount)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    pending.delete();
    mPc      = 0;
    mCount   = 0;
    mHalted  = 1'b0;
    haveLast = 1'b0;
    lastRd   = 0;
  endtask

  // Drives one cycle of inputs, compares DUT outputs to the model, then
  // advances the model across the coming rising edge.
  task automatic applyStimulus(input bit v, input logic [19:0] data, input bit exr);
    bit    expReady;
    bit    acc;
    inst_t it;
    int    op;
    @(negedge clk);
    inValid = v;
    inData  = data;
    exReady = exr;
    #1;
    expReady = !mHalted && ((pending.size() == 0) || exr);
    checkOutput("inReady", 32'(inReady), 32'(expReady));
    checkOutput("decValid", 32'(decValid), 32'(pending.size() != 0));
    checkOutput("halted", 32'(halted), 32'(mHalted));
    checkOutput("instCount", 32'(instCount), 32'(mCount));
    if (pending.size() != 0) begin
      checkOutput("decOp", 32'(decOp), 32'(pending[0].op));
      checkOutput("decRs1", 32'(decRs1), 32'(pending[0].rs1));
      checkOutput("decRs2", 32'(decRs2), 32'(pending[0].rs2));
      checkOutput("decRd", 32'(decRd), 32'(pending[0].rd));
      checkOutput("decPc", 32'(decPc), 32'(pending[0].pc));
      checkOutput("decHazard", 32'(decHazard), 32'(pending[0].hz));
    end
    acc = v && expReady;
    if ((pending.size() != 0) && exr) begin
      void'(pending.pop_front());
      mCount = (mCount + 1) % 65536;
    end
    if (acc) begin
      op = int'(data / 20'h40000);
      if (op == 3) begin
        mHalted = 1'b1;
      end else begin
        it.op  = op;
        it.rs1 = int'(data / 4096) % 64;
        it.rs2 = int'(data / 64) % 64;
        it.rd  = int'(data) % 64;
        it.pc  = mPc;
`ifdef HAZARD_DETECT_EN
        it.hz  = (haveLast && (it.rs1 == lastRd || it.rs2 == lastRd)) ? 1 : 0;
`else
        it.hz  = 0;
`endif
        haveLast = 1'b1;
        lastRd   = it.rd;
        pending.push_back(it);
      end
      mPc = (mPc + 1) % 32;
    end
  endtask

  // Synchronous reset pulse; afterwards every output must be at its reset value.
  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    inValid = 1'b0;
    exReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelClear();
    checkOutput("rstValid", 32'(decValid), 32'd0);
    checkOutput("rstCount", 32'(instCount), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
    checkOutput("rstReady", 32'(inReady), 32'd1);
    checkOutput("rstFields", {18'd0, decOp, decRs1, decRs2, decRd},
                32'd0);
    checkOutput("rstPc", 32'(decPc), 32'd0);
    checkOutput("rstHazard", 32'(decHazard), 32'd0);
  endtask

  function automatic logic [19:0] randWord(input int haltPct);
    logic [19:0] w;
    logic [1:0]  op;
    op = ($urandom_range(0, 99) < haltPct) ? 2'd3 : 2'($urandom_range(0, 2));
    w  = {op, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
          6'($urandom_range(0, 7))};
    return w;
  endfunction

  // Directed scenarios first, then a long randomized run with occasional resets.
  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    inData  = '0;
    exReady = 1'b0;
    modelClear();
    repeat (2) @(posedge clk);
    doReset();

    applyStimulus(1, 20'h00042, 1);
    applyStimulus(1, 20'h4928B, 1);
    applyStimulus(0, 20'h0, 1);
    applyStimulus(0, 20'h0, 1);

    applyStimulus(1, 20'h01083, 0);
    applyStimulus(1, 20'h12345, 0);
    applyStimulus(1, 20'h12345, 0);
    applyStimulus(1, 20'h12345, 0);
    applyStimulus(1, 20'h12345, 1);
    applyStimulus(0, 20'h0, 1);
    applyStimulus(0, 20'h0, 1);

    doReset();
    applyStimulus(1, 20'h00042, 1);
    applyStimulus(1, 20'hC0000, 1);
    applyStimulus(1, 20'h4928B, 1);
    applyStimulus(1, 20'h00042, 1);
    applyStimulus(0, 20'h0, 1);

    doReset();
    for (int i = 0; i < 33; i++) applyStimulus(1, randWord(0), 1);
    applyStimulus(0, 20'h0, 1);

    doReset();
    applyStimulus(1, 20'h00042, 1);
    applyStimulus(1, 20'h02003, 1);
    applyStimulus(0, 20'h0, 1);

    applyStimulus(1, 20'h00042, 0);
    applyStimulus(0, 20'h0, 0);
    doReset();
    applyStimulus(0, 20'h0, 1);

    for (int i = 0; i < 3000; i++) begin
      if (($urandom_range(0, 299) == 0) || (mHalted && $urandom_range(0, 9) == 0))
        doReset();
      else
        applyStimulus($urandom_range(0, 3) != 0, randWord(2),
                      $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
